// File: rtl/sd_cmd_ctrl.sv
// sd_cmd_ctrl -- SD card command sequencer (SPI mode).
//
// Sits between a host and a byte-level SPI engine. After reset it powers up
// and initialises the card (80 dummy clocks, CMD0, CMD8, CMD55/ACMD41 loop,
// CMD58), then serves single-block reads (CMD17), streaming 512 bytes.
//
// Optional feature: define SD_CRC16_EN to check the CRC-16-CCITT of each
// data block. Without it the two CRC bytes are clocked and discarded.
//
// Ports:
//   clock, reset       system clock; synchronous active-high reset
//   cmd_read, lba      read request pulse and block address (sampled in idle)
//   busy, error        sequencer busy; sticky error (cleared by reset only)
//   card_hc            card reported CCS=1 (block-addressed SDHC/SDXC)
//   rd_data, rd_valid  streamed read bytes, one strobe per byte
//   spi_start, spi_tx  one-cycle transfer request and byte to send
//   spi_rx, spi_done   received byte and completion pulse from the engine
//   spi_cs, spi_slow   chip select (active low); slow SCLK select
module sd_cmd_ctrl #(
  parameter int NCR_MAX       = 8,
  parameter int INIT_RETRIES  = 1000,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_read,
  input  logic [31:0] lba,
  output logic        busy,
  output logic        error,
  output logic        card_hc,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic [7:0]  spi_rx,
  input  logic        spi_done,
  output logic        spi_cs,
  output logic        spi_slow
);

  localparam int CNT_W = $clog2((TOKEN_TIMEOUT > 512 ? TOKEN_TIMEOUT : 512) + 1);
  localparam int RTY_W = $clog2(INIT_RETRIES + 1);

  typedef enum logic [3:0] {
    S_PWRUP, S_SEP, S_CMD, S_R1, S_RESP, S_TOKEN,
    S_DATA, S_CRC, S_DESEL, S_IDLE, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    C_GO_IDLE, C_IF_COND, C_APP, C_OP_COND, C_READ_OCR, C_READ_BLK
  } cmd_t;

  state_t           state, state_next;
  cmd_t             cmd, cmd_next;
  logic [CNT_W-1:0] cnt;        // bytes (or polls) within the current state
  logic [RTY_W-1:0] retry_cnt;
  logic             pending;    // a transfer is outstanding in the engine
  logic             done_evt;
  logic             issue;
  logic             init_done;
  logic [31:0]      lba_q;
  logic [7:0]       resp_prev;
  logic [31:0]      arg;
  logic [7:0]       idx_byte, crc_byte;
  logic             crc_bad;

  // A done pulse only counts for a transfer this block started; stale pulses
  // from a transfer launched before reset are dropped.
  assign done_evt = spi_done & pending;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_PWRUP;
      cmd   <= C_GO_IDLE;
    end else begin
      state <= state_next;
      cmd   <= cmd_next;
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pending   <= 1'b0;
      spi_start <= 1'b0;
      cnt       <= '0;
      retry_cnt <= '0;
      init_done <= 1'b0;
      card_hc   <= 1'b0;
      lba_q     <= '0;
      resp_prev <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      spi_start <= issue;
      if (issue)         pending <= 1'b1;
      else if (done_evt) pending <= 1'b0;

      rd_valid <= (state == S_DATA) && done_evt;
      if ((state == S_DATA) && done_evt) rd_data <= spi_rx;

      // Counter restarts on every state change; a 511->0 wrap on data exit
      // falls out of this naturally.
      if (state_next != state) cnt <= '0;
      else if (done_evt)       cnt <= cnt + 1'b1;

      if ((state == S_RESP) && done_evt) resp_prev <= spi_rx;
      if ((state == S_RESP) && done_evt && (cmd == C_READ_OCR) && (cnt == '0))
        card_hc <= spi_rx[6];   // OCR[30] = CCS, first OCR byte is OCR[31:24]
      if ((state == S_R1) && done_evt && (cmd == C_OP_COND) && (spi_rx == 8'h01))
        retry_cnt <= retry_cnt + 1'b1;
      if (state_next == S_IDLE) init_done <= 1'b1;
      if ((state == S_IDLE) && cmd_read) lba_q <= lba;
    end
  end

`ifdef SD_CRC16_EN
  logic [15:0] crc16;
  logic [7:0]  crc_hi;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      crc16  <= '0;
      crc_hi <= '0;
    end else begin
      if (state == S_TOKEN)                   crc16 <= '0;
      else if ((state == S_DATA) && done_evt) crc16 <= crc16_step(crc16, spi_rx);
      if ((state == S_CRC) && done_evt)       crc_hi <= spi_rx;
    end
  end

  // Evaluated on the second CRC byte: crc_hi holds the first (MSB) one.
  assign crc_bad = ({crc_hi, spi_rx} != crc16);
`else
  assign crc_bad = 1'b0;
`endif

  // Next-state logic
  // NOTE: every always_comb output gets a default first so no path can
  // infer a latch.
  always_comb begin
    state_next = state;
    cmd_next   = cmd;
    case (state)
      S_PWRUP: if (done_evt && (cnt == CNT_W'(9))) begin
        state_next = S_CMD;
        cmd_next   = C_GO_IDLE;
      end
      S_SEP: if (done_evt) state_next = S_CMD;
      S_CMD: if (done_evt && (cnt == CNT_W'(5))) state_next = S_R1;
      S_R1: if (done_evt) begin
        if (spi_rx[7]) begin
          if (cnt == CNT_W'(NCR_MAX - 1)) state_next = S_ERROR;
        end else begin
          state_next = S_ERROR;
          case (cmd)
            C_GO_IDLE:  if (spi_rx == 8'h01) begin state_next = S_SEP; cmd_next = C_IF_COND; end
            C_IF_COND:  if (spi_rx == 8'h01) state_next = S_RESP;
            C_APP:      if (spi_rx[7:1] == 7'd0) begin state_next = S_SEP; cmd_next = C_OP_COND; end
            C_OP_COND: begin
              if (spi_rx == 8'h00) begin
                state_next = S_SEP;
                cmd_next   = C_READ_OCR;
              end else if ((spi_rx == 8'h01) && (retry_cnt != RTY_W'(INIT_RETRIES - 1))) begin
                state_next = S_SEP;
                cmd_next   = C_APP;
              end
            end
            C_READ_OCR: if (spi_rx == 8'h00) state_next = S_RESP;
            C_READ_BLK: if (spi_rx == 8'h00) state_next = S_TOKEN;
            default: ;
          endcase
        end
      end
      S_RESP: if (done_evt && (cnt == CNT_W'(3))) begin
        if (cmd == C_IF_COND) begin
          if ((resp_prev == 8'h01) && (spi_rx == 8'hAA)) begin
            state_next = S_SEP;
            cmd_next   = C_APP;
          end else begin
            state_next = S_ERROR;
          end
        end else begin
          state_next = S_DESEL;
        end
      end
      S_TOKEN: if (done_evt) begin
        if (spi_rx == 8'hFE)                           state_next = S_DATA;
        else if (spi_rx != 8'hFF)                      state_next = S_ERROR;
        else if (cnt == CNT_W'(TOKEN_TIMEOUT - 1))     state_next = S_ERROR;
      end
      S_DATA:  if (done_evt && (cnt == CNT_W'(511))) state_next = S_CRC;
      S_CRC:   if (done_evt && (cnt == CNT_W'(1))) state_next = crc_bad ? S_ERROR : S_DESEL;
      S_DESEL: if (done_evt) state_next = S_IDLE;
      S_IDLE:  if (cmd_read) begin
        state_next = S_CMD;
        cmd_next   = C_READ_BLK;
      end
      S_ERROR: ;
      default: state_next = S_ERROR;
    endcase
  end

  // Outputs
  always_comb begin
    idx_byte = 8'h40;
    arg      = '0;
    crc_byte = 8'h01;
    case (cmd)
      C_GO_IDLE:  crc_byte = 8'h95;
      C_IF_COND:  begin idx_byte = 8'h48; arg = 32'h0000_01AA; crc_byte = 8'h87; end
      C_APP:      idx_byte = 8'h77;
      C_OP_COND:  begin idx_byte = 8'h69; arg = 32'h4000_0000; end
      C_READ_OCR: idx_byte = 8'h7A;
      C_READ_BLK: begin
        idx_byte = 8'h51;
        arg      = card_hc ? lba_q : {lba_q[22:0], 9'b0};  // byte address for SDSC
      end
      default: ;
    endcase

    spi_tx = 8'hFF;
    if (state == S_CMD) begin
      case (cnt[2:0])
        3'd0:    spi_tx = idx_byte;
        3'd1:    spi_tx = arg[31:24];
        3'd2:    spi_tx = arg[23:16];
        3'd3:    spi_tx = arg[15:8];
        3'd4:    spi_tx = arg[7:0];
        3'd5:    spi_tx = crc_byte;
        default: spi_tx = 8'hFF;
      endcase
    end

    spi_cs   = !(state inside {S_CMD, S_R1, S_RESP, S_TOKEN, S_DATA, S_CRC});
    busy     = !(state inside {S_IDLE, S_ERROR});
    error    = (state == S_ERROR);
    spi_slow = !init_done;
    issue    = !(state inside {S_IDLE, S_ERROR}) && !pending;
  end

endmodule
